mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Replaces the separate MUL/MULTU/DIV/DIVU instances, the two HI/LO sregisters and the negedge start-pulse logic with one block.
- Handles signed and unsigned multiply and divide, plus MTHI/MTLO writes.
- Exposes a busy/done handshake that the control unit uses to stall the PC.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 132 +++++++++++++
 tb/tb_mdu_iter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Command/result bus of the iterative multiply/divide unit.
// The core drives the command side; the unit owns busy/done and HI/LO.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Signed ops run on magnitudes; signs are applied in a single fix-up cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r_q;
  logic               div0_q;
  logic               busy_q;
  logic               done_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.rs[WIDTH-1];
    b_neg     = signed_op & bus.rt[WIDTH-1];
    a_mag     = a_neg ? -bus.rs : bus.rs;
    b_mag     = b_neg ? -bus.rt : bus.rt;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
    // A zero divisor always subtracts, giving an all-ones quotient and rem = dividend.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_next  = div_ok ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.op[2]) begin
            is_div_q <= bus.op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            div0_q   <= (bus.rt == '0);
            opb_q    <= bus.op[1] ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else if (bus.start && bus.op[1:0] == 2'b00) begin
            hi_q <= bus.rs;
          end else if (bus.start && bus.op[1:0] == 2'b01) begin
            lo_q <= bus.rs;
          end
        end
        StRun: begin
          if (bus.cancel) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          if (!bus.cancel) begin
            if (is_div_q) begin
              lo_q <= div0_q ? '1 : quo_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_mdu_iter;
  typedef struct {
    logic [63:0] res;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) if32 ();
  mdu_iter_if #(.WIDTH(8))  if8 ();

  mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one start strobe in the current cycle; returns at the next falling edge.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit push, input logic [63:0] exp,
                       input string tag);
    if (w8) begin
      if8.start = 1'b1; if8.op = op; if8.rs = rs[7:0]; if8.rt = rt[7:0];
    end else begin
      if32.start = 1'b1; if32.op = op; if32.rs = rs; if32.rt = rt;
    end
    if (push) sb.push_back('{res: exp, tag: tag});
    @(negedge clk);
    if8.start  = 1'b0;
    if32.start = 1'b0;
  endtask

  task automatic wait_done(input bit w8, input int exp_busy);
    int          busy_cnt = 0;
    int          guard    = 0;
    exp_t        e;
    logic [63:0] obs;
    while (!(w8 ? if8.done : if32.done) && guard < 200) begin
      if (w8 ? if8.busy : if32.busy) busy_cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      compared++;
      mismatched++;
      $error("FAIL timeout: done observed 0 after 200 cycles, required 1");
      return;
    end
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard: done observed 1 with no pending result, required 0");
      return;
    end
    e   = sb.pop_front();
    obs = w8 ? {24'h0, if8.hi, 24'h0, if8.lo} : {if32.hi, if32.lo};
    check({e.tag, " hi/lo"}, obs, e.res);
    check({e.tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    if32.start = 1'b0; if32.op = 3'b0; if32.rs = '0; if32.rt = '0; if32.cancel = 1'b0;
    if8.start  = 1'b0; if8.op  = 3'b0; if8.rs  = '0; if8.rt  = '0; if8.cancel  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset hi/lo", {if32.hi, if32.lo}, 64'h0);
    check("reset busy/done", {62'h0, if32.busy, if32.done}, 64'h0);

    issue(1'b0, 3'b000, 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB, "mult -3*7");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001, "multu max");
    check("done one cycle", {63'h0, if32.done}, 64'h0);
    wait_done(1'b0, 33);
    issue(1'b0, 3'b011, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, "divu 100/7");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b010, 32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "div -7/2");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "div ovf");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b010, 32'h5, 32'h0, 1'b1, 64'h00000005_FFFFFFFF, "div 5/0");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b010, 32'hFFFFFFF9, 32'h0, 1'b1, 64'hFFFFFFF9_FFFFFFFF, "div -7/0");
    wait_done(1'b0, 33);
    issue(1'b0, 3'b011, 32'h12345678, 32'h0, 1'b1, 64'h12345678_FFFFFFFF, "divu x/0");
    wait_done(1'b0, 33);

    issue(1'b0, 3'b100, 32'h12345678, 32'h0, 1'b0, 64'h0, "");
    check("mthi", {31'h0, if32.busy, if32.hi}, {32'h0, 32'h12345678});
    issue(1'b0, 3'b101, 32'h9ABCDEF0, 32'h0, 1'b0, 64'h0, "");
    check("mtlo", {31'h0, if32.busy, if32.lo}, {32'h0, 32'h9ABCDEF0});

    issue(1'b0, 3'b000, 32'h00010000, 32'h00010000, 1'b1, 64'h00000001_00000000, "mult mid-mthi");
    repeat (4) @(negedge clk);
    if32.start = 1'b1; if32.op = 3'b100; if32.rs = 32'hAAAAAAAA;
    @(negedge clk);
    if32.start = 1'b0;
    check("mthi while busy", {if32.hi, if32.lo}, 64'h12345678_9ABCDEF0);
    wait_done(1'b0, 28);

    issue(1'b0, 3'b110, 32'hDEADBEEF, 32'h1, 1'b0, 64'h0, "");
    check("op 110 ignored", {31'h0, if32.busy, if32.hi}, {32'h0, 32'h00000001});

    if32.cancel = 1'b1;
    issue(1'b0, 3'b001, 32'd3, 32'd5, 1'b1, 64'h00000000_0000000F, "multu cancel+start");
    if32.cancel = 1'b0;
    wait_done(1'b0, 33);

    issue(1'b0, 3'b011, 32'd1000, 32'd3, 1'b0, 64'h0, "");
    repeat (9) @(negedge clk);
    if32.cancel = 1'b1;
    @(negedge clk);
    if32.cancel = 1'b0;
    check("cancel busy/done", {62'h0, if32.busy, if32.done}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.done) seen++;
    end
    check("cancel no done", 64'(seen), 64'h0);
    check("cancel hi/lo kept", {if32.hi, if32.lo}, 64'h00000000_0000000F);

    issue(1'b0, 3'b011, 32'd1000, 32'd3, 1'b0, 64'h0, "");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset mid-op hi/lo", {if32.hi, if32.lo}, 64'h0);
    check("reset mid-op busy", {63'h0, if32.busy}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 3'b000, 32'h80, 32'h80, 1'b1, {24'h0, 8'h40, 24'h0, 8'h00}, "w8 mult 80*80");
    wait_done(1'b1, 9);
    issue(1'b1, 3'b010, 32'h80, 32'hFF, 1'b1, {24'h0, 8'h00, 24'h0, 8'h80}, "w8 div ovf");
    check("w8 done drops", {63'h0, if8.done}, 64'h0);
    wait_done(1'b1, 9);
    issue(1'b1, 3'b011, 32'd200, 32'd7, 1'b1, {24'h0, 8'h04, 24'h0, 8'h1C}, "w8 divu 200/7");
    wait_done(1'b1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
